// File: rtl/noc_topology_pkg.sv
// Shared definitions for the buffered NoC topology: topology encodings,
// control-bit positions inside a port word, and the neighbour function.
package noc_topology_pkg;

  typedef enum logic [1:0] {
    TOPO_MESH      = 2'd0,
    TOPO_TORUS     = 2'd1,
    TOPO_CIRCULANT = 2'd2
  } topology_e;

  // Bit positions counted down from PORT_SIZE: ready is the MSB, valid just below.
  localparam int READY_FROM_MSB = 1;
  localparam int VALID_FROM_MSB = 2;
  localparam int NO_NEIGHBOUR   = -1;

  // Neighbour of node n on port p, or NO_NEIGHBOUR when the port is unconnected.
  function automatic int neighbour(input int topology, input int nodes, input int h_size,
                                   input int s0, input int s1, input int n, input int p);
    int m;
    int col;
    int row_base;
    m = NO_NEIGHBOUR;
    case (topology)
      int'(TOPO_MESH): begin
        col = n % h_size;
        case (p)
          0: m = (col + 1 < h_size) ? n + 1 : NO_NEIGHBOUR;
          1: m = (col > 0) ? n - 1 : NO_NEIGHBOUR;
          2: m = (n + h_size < nodes) ? n + h_size : NO_NEIGHBOUR;
          3: m = (n >= h_size) ? n - h_size : NO_NEIGHBOUR;
          default: m = NO_NEIGHBOUR;
        endcase
      end
      int'(TOPO_TORUS): begin
        col      = n % h_size;
        row_base = n - col;
        case (p)
          0: m = row_base + (col + 1) % h_size;
          1: m = row_base + (col + h_size - 1) % h_size;
          2: m = (n + h_size) % nodes;
          3: m = (n + nodes - h_size) % nodes;
          default: m = NO_NEIGHBOUR;
        endcase
      end
      int'(TOPO_CIRCULANT): begin
        case (p)
          0: m = (n + s0) % nodes;
          1: m = (n + nodes - s0) % nodes;
          2: m = (n + s1) % nodes;
          3: m = (n + nodes - s1) % nodes;
          default: m = NO_NEIGHBOUR;
        endcase
      end
      default: m = NO_NEIGHBOUR;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/link_fifo.sv
// One directed link: a BUF_DEPTH-entry FIFO with valid/ready on both sides.
// A pushed flit is visible at the output right after the pushing edge.
module link_fifo #(
  parameter int DATA_W    = 37,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(BUF_DEPTH);

  logic [DATA_W-1:0] mem_r [BUF_DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              alive_r;
  logic              push_s;
  logic              pop_s;

  // alive_r keeps ready low until the first edge after reset release.
  assign in_ready  = alive_r & (count_r != FULL_CNT);
  assign out_valid = (count_r != {(AW + 1){1'b0}});
  assign out_data  = out_valid ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Pointer, occupancy and liveness state; pointers wrap naturally at BUF_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
      alive_r  <= 1'b0;
    end else begin
      alive_r <= 1'b1;
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, written on push only.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= in_data;
  end

endmodule

// File: rtl/buffered_topology.sv
// Buffered NoC fabric: every connected directed port pair n:p -> m:p^1 gets
// its own link_fifo; unconnected ports output zero and ignore their input.
module buffered_topology
  import noc_topology_pkg::*;
#(
  parameter int PORT_SIZE = 39,
  parameter int PORTS_NUM = 4,
  parameter int NODES_NUM = 4,
  parameter int TOPOLOGY  = 0,
  parameter int H_SIZE    = 2,
  parameter int S0        = 1,
  parameter int S1        = 2,
  parameter int BUF_DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NODES_NUM*PORTS_NUM*PORT_SIZE-1:0] data_i,
  output logic [NODES_NUM*PORTS_NUM*PORT_SIZE-1:0] data_o
);

  localparam int DATA_W = PORT_SIZE - 2;
  localparam int LINKS  = NODES_NUM * PORTS_NUM;
  localparam int RDY    = PORT_SIZE - READY_FROM_MSB;
  localparam int VLD    = PORT_SIZE - VALID_FROM_MSB;

  if (PORT_SIZE < 3) begin : g_bad_port_size
    $error("buffered_topology: PORT_SIZE must be at least 3");
  end
  if (PORTS_NUM != 4) begin : g_bad_ports
    $error("buffered_topology: PORTS_NUM must be 4");
  end
  if (NODES_NUM < 2) begin : g_bad_nodes
    $error("buffered_topology: NODES_NUM must be at least 2");
  end
  if (TOPOLOGY < 0 || TOPOLOGY > 2) begin : g_bad_topology
    $error("buffered_topology: TOPOLOGY must be 0, 1 or 2");
  end
  if (TOPOLOGY != int'(TOPO_CIRCULANT) && (H_SIZE < 1 || (NODES_NUM % H_SIZE) != 0)) begin : g_bad_h
    $error("buffered_topology: NODES_NUM must be a multiple of H_SIZE");
  end
  if (S0 < 1 || S0 > NODES_NUM - 1 || S1 < 1 || S1 > NODES_NUM - 1) begin : g_bad_steps
    $error("buffered_topology: S0/S1 must be in 1..NODES_NUM-1");
  end
  if (BUF_DEPTH < 2 || BUF_DEPTH > 16 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("buffered_topology: BUF_DEPTH must be a power of two in 2..16");
  end

  logic [LINKS-1:0]  link_valid_s;
  logic [LINKS-1:0]  link_ready_s;
  logic [DATA_W-1:0] link_data_s [LINKS];

  for (genvar n = 0; n < NODES_NUM; n++) begin : g_node
    for (genvar p = 0; p < PORTS_NUM; p++) begin : g_port
      localparam int IDX = n * PORTS_NUM + p;
      localparam int M   = neighbour(TOPOLOGY, NODES_NUM, H_SIZE, S0, S1, n, p);

      if (M >= 0) begin : g_link
        // PEER is the facing port m:p^1; its outgoing link feeds this port's output.
        localparam int PEER = M * PORTS_NUM + (p ^ 1);

        link_fifo #(
          .DATA_W   (DATA_W),
          .BUF_DEPTH(BUF_DEPTH)
        ) u_link_fifo (
          .clk      (clk),
          .rst_n    (rst_n),
          .in_valid (data_i[IDX*PORT_SIZE + VLD]),
          .in_data  (data_i[IDX*PORT_SIZE +: DATA_W]),
          .in_ready (link_ready_s[IDX]),
          .out_valid(link_valid_s[IDX]),
          .out_data (link_data_s[IDX]),
          .out_ready(data_i[PEER*PORT_SIZE + RDY])
        );

        assign data_o[IDX*PORT_SIZE +: PORT_SIZE] =
          {link_ready_s[IDX], link_valid_s[PEER], link_data_s[PEER]};
      end else begin : g_open
        logic unused_port_s;

        assign link_ready_s[IDX] = 1'b0;
        assign link_valid_s[IDX] = 1'b0;
        assign link_data_s[IDX]  = {DATA_W{1'b0}};
        assign data_o[IDX*PORT_SIZE +: PORT_SIZE] = {PORT_SIZE{1'b0}};
        assign unused_port_s = ^data_i[IDX*PORT_SIZE +: PORT_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_buffered_topology.sv
// Directed bench: mesh, torus and circulant instances driven side by side,
// each step checked with an immediate assertion against hand-derived values.
module tb_buffered_topology;

  localparam int PS = 39;
  localparam int DW = 37;

  logic clk;
  logic rst_n;
  logic [4*4*PS-1:0] din_m, dout_m;
  logic [4*4*PS-1:0] din_t, dout_t;
  logic [5*4*PS-1:0] din_c, dout_c;

  // Per-port views: index 0 = mesh, 1 = torus, 2 = circulant.
  logic          i_rdy [3][20];
  logic          i_vld [3][20];
  logic [DW-1:0] i_dat [3][20];
  logic          o_rdy [3][20];
  logic          o_vld [3][20];
  logic [DW-1:0] o_dat [3][20];

  int n_checks;
  int n_fail;

  buffered_topology #(.PORT_SIZE(PS), .PORTS_NUM(4), .NODES_NUM(4), .TOPOLOGY(0),
                      .H_SIZE(2), .S0(1), .S1(2), .BUF_DEPTH(2))
    u_mesh (.clk(clk), .rst_n(rst_n), .data_i(din_m), .data_o(dout_m));

  buffered_topology #(.PORT_SIZE(PS), .PORTS_NUM(4), .NODES_NUM(4), .TOPOLOGY(1),
                      .H_SIZE(2), .S0(1), .S1(2), .BUF_DEPTH(2))
    u_torus (.clk(clk), .rst_n(rst_n), .data_i(din_t), .data_o(dout_t));

  buffered_topology #(.PORT_SIZE(PS), .PORTS_NUM(4), .NODES_NUM(5), .TOPOLOGY(2),
                      .H_SIZE(1), .S0(1), .S1(2), .BUF_DEPTH(2))
    u_circ (.clk(clk), .rst_n(rst_n), .data_i(din_c), .data_o(dout_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      din_m[k*PS +: PS] = {i_rdy[0][k], i_vld[0][k], i_dat[0][k]};
      din_t[k*PS +: PS] = {i_rdy[1][k], i_vld[1][k], i_dat[1][k]};
    end
    for (int k = 0; k < 20; k++) begin
      din_c[k*PS +: PS] = {i_rdy[2][k], i_vld[2][k], i_dat[2][k]};
    end
  end

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 20; k++) begin
        o_rdy[d][k] = 1'b0;
        o_vld[d][k] = 1'b0;
        o_dat[d][k] = '0;
      end
    end
    for (int k = 0; k < 16; k++) begin
      {o_rdy[0][k], o_vld[0][k], o_dat[0][k]} = dout_m[k*PS +: PS];
      {o_rdy[1][k], o_vld[1][k], o_dat[1][k]} = dout_t[k*PS +: PS];
    end
    for (int k = 0; k < 20; k++) begin
      {o_rdy[2][k], o_vld[2][k], o_dat[2][k]} = dout_c[k*PS +: PS];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] word(input int d, input int k);
    return 64'({o_rdy[d][k], o_vld[d][k], o_dat[d][k]});
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 20; k++) begin
        i_rdy[d][k] = 1'b0;
        i_vld[d][k] = 1'b0;
        i_dat[d][k] = '0;
      end
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    check("reset_mesh_all_zero", 64'(|dout_m), 64'd0);
    check("reset_torus_all_zero", 64'(|dout_t), 64'd0);
    check("reset_circ_all_zero", 64'(|dout_c), 64'd0);

    #8 rst_n = 1'b1;
    #1;
    check("ready_low_before_edge", 64'(o_rdy[0][0]), 64'd0);
    tick();
    check("ready_after_edge", 64'(o_rdy[0][0]), 64'd1);
    check("mesh_open_port_zero", word(0, 1), 64'd0);
    check("circ_ready_after_edge", 64'(o_rdy[2][18]), 64'd1);

    // Mesh single flit: node0 port0 -> node1 port1; open port 0:1 driven but ignored.
    i_rdy[0][5] = 1'b1;
    i_vld[0][0] = 1'b1; i_dat[0][0] = 37'h15;
    i_vld[0][1] = 1'b1; i_dat[0][1] = 37'h3F;
    tick();
    i_vld[0][0] = 1'b0; i_vld[0][1] = 1'b0;
    check("mesh_flit_valid", 64'(o_vld[0][5]), 64'd1);
    check("mesh_flit_data", 64'(o_dat[0][5]), 64'h15);
    check("mesh_open_port_quiet", word(0, 1), 64'd0);
    tick();
    check("mesh_flit_drained", 64'(o_vld[0][5]), 64'd0);

    // Backpressure: three offers into a depth-2 link while the sink stalls.
    i_rdy[0][5] = 1'b0;
    i_vld[0][0] = 1'b1; i_dat[0][0] = 37'h21;
    tick();
    i_dat[0][0] = 37'h22;
    tick();
    check("bp_full_ready_low", 64'(o_rdy[0][0]), 64'd0);
    i_dat[0][0] = 37'h23;
    tick();
    i_vld[0][0] = 1'b0;
    check("bp_head_first", word(0, 5), {25'd0, 1'b1, 1'b1, 37'h21});
    check("bp_still_full", 64'(o_rdy[0][0]), 64'd0);
    i_rdy[0][5] = 1'b1;
    tick();
    check("bp_head_second", word(0, 5), {25'd0, 1'b1, 1'b1, 37'h22});
    check("bp_ready_back", 64'(o_rdy[0][0]), 64'd1);
    tick();
    check("bp_third_dropped", 64'(o_vld[0][5]), 64'd0);

    // Torus wrap links and circulant modulo links, all offered in the same cycle.
    i_vld[1][4]  = 1'b1; i_dat[1][4]  = 37'hA;
    i_vld[1][3]  = 1'b1; i_dat[1][3]  = 37'hB;
    i_vld[2][18] = 1'b1; i_dat[2][18] = 37'h7;
    i_vld[2][1]  = 1'b1; i_dat[2][1]  = 37'h3;
    tick();
    i_vld[1][4] = 1'b0; i_vld[1][3] = 1'b0; i_vld[2][18] = 1'b0; i_vld[2][1] = 1'b0;
    check("torus_n1p0_to_n0p1", word(1, 1), {25'd0, 1'b1, 1'b1, 37'hA});
    check("torus_n0p3_to_n2p2", word(1, 10), {25'd0, 1'b1, 1'b1, 37'hB});
    check("circ_n4p2_to_n1p3", word(2, 7), {25'd0, 1'b1, 1'b1, 37'h7});
    check("circ_n0p1_to_n4p0", word(2, 16), {25'd0, 1'b1, 1'b1, 37'h3});

    // Streaming: 100 back-to-back flits, each visible right after its push.
    for (int i = 0; i < 100; i++) begin
      i_vld[0][0] = 1'b1;
      i_dat[0][0] = 37'(i + 256);
      tick();
      check("stream_flit", 64'({o_rdy[0][0], o_vld[0][5], o_dat[0][5]}),
            64'({1'b1, 1'b1, 37'(i + 256)}));
    end
    i_vld[0][0] = 1'b0;
    tick();
    check("stream_done", 64'(o_vld[0][5]), 64'd0);

    // Reset mid-stream: one flit held, then an asynchronous reset pulse.
    i_rdy[0][5] = 1'b0;
    i_vld[0][0] = 1'b1; i_dat[0][0] = 37'h55;
    tick();
    i_vld[0][0] = 1'b0;
    check("rst_flit_held", word(0, 5), {25'd0, 1'b1, 1'b1, 37'h55});
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_mesh_zero", 64'(|dout_m), 64'd0);
    check("rst_async_torus_zero", 64'(|dout_t), 64'd0);
    tick();
    i_rdy[0][5] = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    check("rst_flit_discarded", word(0, 5), {25'd0, 1'b1, 1'b0, 37'h0});
    tick();
    check("rst_flit_never_seen", 64'(o_vld[0][5]), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/buffered_topology.md
BUFFERED_TOPOLOGY -- requirements
Module: buffered_topology

Interface
REQ-001 SHALL have parameter PORT_SIZE, default 39, meaning port word width: bit PORT_SIZE-1 = ready, bit PORT_SIZE-2 = valid, bits PORT_SIZE-3:0 = data (DATA_W = PORT_SIZE-2).
REQ-002 SHALL have parameter PORTS_NUM, default 4, meaning ports per node; only the value 4 is legal.
REQ-003 SHALL have parameter NODES_NUM, default 4, meaning node count; it SHALL be at least 2.
REQ-004 SHALL have parameter TOPOLOGY, default 0, meaning link pattern: 0 = mesh_2d, 1 = torus, 2 = circulant_2.
REQ-005 SHALL have parameter H_SIZE, default 2, meaning row length for mesh/torus; NODES_NUM SHALL be a multiple of H_SIZE.
REQ-006 SHALL have parameters S0, default 1, and S1, default 2, meaning circulant steps; both SHALL be in 1..NODES_NUM-1.
REQ-007 SHALL have parameter BUF_DEPTH, default 2, meaning per-link FIFO depth; legal values are powers of two from 2 to 16.
REQ-008 SHALL have clk  input  1  system clock; all state on rising edge.
REQ-009 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-010 SHALL have data_i  input  NODES_NUM*PORTS_NUM*PORT_SIZE  words from nodes; node n, port p at offset (n*PORTS_NUM+p)*PORT_SIZE.
REQ-011 SHALL have data_o  output  NODES_NUM*PORTS_NUM*PORT_SIZE  words to nodes; same layout as data_i.
REQ-012 SHALL fail elaboration on any illegal parameter value.

Function
REQ-013 SHALL give port p of node n the neighbour m(n,p); the neighbour's facing port SHALL be p^1.
- Port 0 = +1 / +S0; port 1 = -1 / -S0.
- Port 2 = +H_SIZE / +S1; port 3 = -H_SIZE / -S1.
REQ-014 Mesh: a neighbour that falls outside its row (ports 0/1) or outside 0..NODES_NUM-1 (ports 2/3) SHALL leave that port unconnected.
REQ-015 Torus: ports 0/1 SHALL wrap within the row; ports 2/3 SHALL wrap modulo NODES_NUM.
REQ-016 Circulant: all neighbours SHALL be taken modulo NODES_NUM.
REQ-017 Each connected directed link n:p -> m:p^1 SHALL own one BUF_DEPTH FIFO.
- Push: data_i[n:p].valid and the FIFO is not full.
- Pop: the FIFO is not empty and data_i[m:p^1].ready is 1.
REQ-018 data_o[m:p^1] SHALL carry valid = FIFO not empty and data = FIFO head; its ready bit SHALL be not-full of the FIFO on link m:p^1 -> n:p.
REQ-019 Minimum forward latency SHALL be 1 cycle: a flit pushed at edge k is visible at data_o at edge k.
REQ-020 With the FIFO empty, no bypass SHALL exist.
REQ-021 Sustained throughput SHALL be 1 flit/cycle per link while the downstream ready stays 1.
REQ-022 Push and pop in the same cycle SHALL leave occupancy unchanged; at full, ready = 0, so only a pop is possible.
REQ-023 Read and write pointers SHALL wrap modulo BUF_DEPTH; occupancy SHALL be held in log2(BUF_DEPTH)+1 bits.
REQ-024 Head data SHALL remain stable while valid = 1 and ready = 0.
REQ-025 Unconnected ports SHALL drive an all-zero data_o word, and their data_i SHALL be ignored.
REQ-026 data_i data bits SHALL be ignored when valid = 0.

Reset
REQ-027 While rst_n = 0, all FIFOs SHALL be empty with pointers at 0.
REQ-028 While rst_n = 0, every data_o valid SHALL be 0 and every ready SHALL be 0.
REQ-029 Reset asserted mid-transfer SHALL discard buffered flits immediately, with no partial output.
REQ-030 Ready SHALL rise to 1 on the first clk edge after rst_n deasserts.
REQ-031 FIFO storage arrays SHALL need no reset.

Structure
REQ-032 Package noc_topology_pkg SHALL hold TOPOLOGY encodings, ready/valid bit-position constants and the neighbour function m(n,p).
REQ-033 Sub-module link_fifo(DATA_W, BUF_DEPTH) SHALL implement one directed link.
REQ-034 The top level SHALL be generate loops over nodes and ports only.

Verification
REQ-035 Mesh, N=4, H=2: node0 port0 sends 0x15 with node1 port1 ready=1 -> data_o[1:1] valid=1, data=0x15 one cycle later; data_o[0:1] = 0 throughout.
REQ-036 Backpressure, BUF_DEPTH=2: node1 ready=0, node0 sends 3 flits -> 2 accepted, data_o[0:0].ready = 0; after ready=1 -> flits exit in order, one per cycle.
REQ-037 Torus, N=4, H=2: node1 port0 sends 0xA -> appears at node0 port1; node0 port3 sends 0xB -> appears at node2 port2.
REQ-038 Circulant, N=5, S0=1, S1=2: node4 port2 sends 0x7 -> appears at node1 port3; node0 port1 sends 0x3 -> appears at node4 port0.
REQ-039 Streaming: 100 back-to-back flits with ready=1 -> 100 flits out, in order, no gaps after the first.
REQ-040 Reset mid-stream: 1 flit buffered, rst_n pulsed low -> all valid=0 and ready=0 asynchronously; the flit is never delivered.
